// File: rtl/audio_dac_controller.sv
// Playback serializer for the codec DAC: pops stereo words from a FIFO and shifts them
// out MSB-first, I2S-aligned to the codec-driven LRCK, muting on FIFO underrun.
module audio_dac_controller #(
    parameter logic [4:0] dataLength = 5'd16
) (
    input  logic        AUD_BCLK,
    input  logic        reset,
    input  logic        AUD_DAC_CLK,
    output logic        AUD_DAC_DATA,
    input  logic        rdempty_sig,
    input  logic [31:0] q_sig,
    output logic        rdreq_sig,
    output logic        underrun_sig
);

    typedef enum logic [1:0] {
        WAIT_SYNC = 2'd0,
        LEFT      = 2'd1,
        RIGHT     = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        lrck_q;
    logic [31:0] frame;
    logic [31:0] shadow;
    logic [4:0]  bit_cnt;
    logic        fetch_pend;

    logic [31:0] frame_nxt;
    logic [31:0] shadow_nxt;
    logic [4:0]  bit_cnt_nxt;
    logic        fetch_pend_nxt;
    logic        data_nxt;
    logic        rdreq_nxt;
    logic        underrun_nxt;

    logic rise;
    logic fall;
    logic right_start;

    assign rise        = AUD_DAC_CLK & ~lrck_q;
    assign fall        = ~AUD_DAC_CLK & lrck_q;
    assign right_start = fall && (state != WAIT_SYNC);

    always_ff @(posedge AUD_BCLK or posedge reset) begin
        if (reset) begin
            state <= WAIT_SYNC;
        end else begin
            state <= state_nxt;
        end
    end

    // Any rise restarts the left channel, any fall after sync restarts the right one.
    always_comb begin
        state_nxt = state;
        case (state)
            WAIT_SYNC: if (rise) state_nxt = LEFT;
            LEFT, RIGHT: begin
                if (rise) begin
                    state_nxt = LEFT;
                end else if (fall) begin
                    state_nxt = RIGHT;
                end
            end
            default: state_nxt = WAIT_SYNC;
        endcase
    end

    always_comb begin
        frame_nxt      = frame;
        shadow_nxt     = shadow;
        bit_cnt_nxt    = bit_cnt;
        fetch_pend_nxt = fetch_pend;
        data_nxt       = 1'b0;
        rdreq_nxt      = 1'b0;
        underrun_nxt   = 1'b0;

        // q_sig is valid the cycle after the request pulse, so capture once it has dropped.
        if (fetch_pend && !rdreq_sig) begin
            shadow_nxt     = q_sig;
            fetch_pend_nxt = 1'b0;
        end

        if (rise) begin
            frame_nxt   = shadow;
            data_nxt    = shadow[31];
            bit_cnt_nxt = 5'd1;
            if (!rdempty_sig) begin
                rdreq_nxt      = 1'b1;
                fetch_pend_nxt = 1'b1;
            end else begin
                shadow_nxt     = 32'd0;
                underrun_nxt   = 1'b1;
                fetch_pend_nxt = 1'b0;
            end
        end else if (right_start) begin
            data_nxt    = frame[15];
            bit_cnt_nxt = 5'd1;
        end else if (state == LEFT && bit_cnt < dataLength) begin
            data_nxt    = frame[5'd31 - bit_cnt];
            bit_cnt_nxt = bit_cnt + 5'd1;
        end else if (state == RIGHT && bit_cnt < dataLength) begin
            data_nxt    = frame[5'd15 - bit_cnt];
            bit_cnt_nxt = bit_cnt + 5'd1;
        end
    end

    // lrck_q resets high so an LRCK already high at release is not taken as a rise.
    always_ff @(posedge AUD_BCLK or posedge reset) begin
        if (reset) begin
            lrck_q       <= 1'b1;
            frame        <= 32'd0;
            shadow       <= 32'd0;
            bit_cnt      <= 5'd0;
            fetch_pend   <= 1'b0;
            AUD_DAC_DATA <= 1'b0;
            rdreq_sig    <= 1'b0;
            underrun_sig <= 1'b0;
        end else begin
            lrck_q       <= AUD_DAC_CLK;
            frame        <= frame_nxt;
            shadow       <= shadow_nxt;
            bit_cnt      <= bit_cnt_nxt;
            fetch_pend   <= fetch_pend_nxt;
            AUD_DAC_DATA <= data_nxt;
            rdreq_sig    <= rdreq_nxt;
            underrun_sig <= underrun_nxt;
        end
    end

endmodule

// File: tb/tb_audio_dac_controller.sv
// Bench for audio_dac_controller: two instances (16-bit and 12-bit slots) share one FIFO
// model; a frame-level model queues expected words, a monitor deserializes and compares.
`timescale 1ns/1ps
module tb_audio_dac_controller;

    logic        AUD_BCLK    = 1'b0;
    logic        reset       = 1'b1;
    logic        AUD_DAC_CLK = 1'b1;
    logic        rdempty_sig = 1'b1;
    logic [31:0] q_sig       = 32'd0;
    logic        data16, data12, rdreq16, rdreq12, un16, un12;

    audio_dac_controller #(.dataLength(5'd16)) dut16 (
        .AUD_BCLK(AUD_BCLK), .reset(reset), .AUD_DAC_CLK(AUD_DAC_CLK),
        .AUD_DAC_DATA(data16), .rdempty_sig(rdempty_sig), .q_sig(q_sig),
        .rdreq_sig(rdreq16), .underrun_sig(un16)
    );

    audio_dac_controller #(.dataLength(5'd12)) dut12 (
        .AUD_BCLK(AUD_BCLK), .reset(reset), .AUD_DAC_CLK(AUD_DAC_CLK),
        .AUD_DAC_DATA(data12), .rdempty_sig(rdempty_sig), .q_sig(q_sig),
        .rdreq_sig(rdreq12), .underrun_sig(un12)
    );

    always #5 AUD_BCLK = ~AUD_BCLK;

    // {rdreq expected, underrun expected, word transmitted in this frame}
    logic [33:0] exp_q[$];
    logic [31:0] fifo_q[$];
    logic [31:0] pend_words[$];
    logic [31:0] shadow_model = 32'd0;
    logic [31:0] fifo_word;
    int          n_vec = 0;
    int          n_err = 0;
    int          rd_total = 0;
    int          exp_rd_total = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] lane_mask(input int len);
        logic [15:0] h;
        h = 16'hFFFF << (16 - len);
        return {h, h};
    endfunction

    // Normal-mode FIFO: data appears the cycle after the request.
    always @(posedge AUD_BCLK) begin
        if (rdreq16 && fifo_q.size() > 0) begin
            fifo_word = fifo_q.pop_front();
            q_sig <= fifo_word;
        end
        rdempty_sig <= (fifo_q.size() == 0);
    end

    logic        collecting = 1'b0;
    logic        mon_lr = 1'b1;
    int          bit_idx = 0;
    logic [31:0] rx16, rx12;
    int          rdc16, rdc12, unc16, unc12;
    logic [33:0] e;

    always @(negedge AUD_BCLK) begin
        if (reset) begin
            if (collecting && exp_q.size() > 0) exp_q.delete(0);
            collecting = 1'b0;
            mon_lr = 1'b1;
            check("reset_outputs", {26'd0, data16, data12, rdreq16, rdreq12, un16, un12}, 32'd0);
        end else begin
            if (rdreq16) rd_total++;
            if (collecting) begin
                rx16 = {rx16[30:0], data16};
                rx12 = {rx12[30:0], data12};
                rdc16 += int'(rdreq16);
                rdc12 += int'(rdreq12);
                unc16 += int'(un16);
                unc12 += int'(un12);
                bit_idx++;
                if (bit_idx == 32) begin
                    collecting = 1'b0;
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL frame_queue: got empty queue required an expected frame");
                    end else begin
                        e = exp_q.pop_front();
                        check("frame16", rx16, e[31:0] & lane_mask(16));
                        check("frame12", rx12, e[31:0] & lane_mask(12));
                        check("rdreq16", 32'(rdc16), {31'd0, e[33]});
                        check("rdreq12", 32'(rdc12), {31'd0, e[33]});
                        check("underrun16", 32'(unc16), {31'd0, e[32]});
                        check("underrun12", 32'(unc12), {31'd0, e[32]});
                    end
                end
            end else begin
                check("idle", {26'd0, data16, data12, rdreq16, rdreq12, un16, un12}, 32'd0);
            end
            if (AUD_DAC_CLK && !mon_lr) begin
                collecting = 1'b1;
                bit_idx = 0;
                rdc16 = 0; rdc12 = 0; unc16 = 0; unc12 = 0;
            end
            mon_lr = AUD_DAC_CLK;
        end
    end

    task automatic step();
        @(posedge AUD_BCLK);
        #2;
    endtask

    task automatic load_pending();
        while (pend_words.size() > 0) fifo_q.push_back(pend_words.pop_front());
    endtask

    // One 32-BCLK frame; rst_at >= 0 pulses reset while that left-slot bit is on the line.
    task automatic frame(input int rst_at);
        logic [31:0] w;
        logic        rd;
        w  = shadow_model;
        rd = (fifo_q.size() > 0);
        shadow_model = rd ? fifo_q[0] : 32'd0;
        if (rd) exp_rd_total++;
        exp_q.push_back({rd, ~rd, w});
        AUD_DAC_CLK = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step();
            if (i == rst_at) begin
                reset = 1'b1;
                shadow_model = 32'd0;
                #1 check("reset_immediate", {30'd0, data16, data12}, 32'd0);
            end
            if (rst_at >= 0 && i == rst_at + 3) reset = 1'b0;
        end
        AUD_DAC_CLK = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step();
            if (i == 3) load_pending();
        end
    endtask

    initial begin
        repeat (3) step();
        reset = 1'b0;

        // LRCK high at release: a full frame passes with no rise seen.
        pend_words.push_back(32'hA5C3_0F81);
        for (int i = 0; i < 16; i++) step();
        AUD_DAC_CLK = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step();
            if (i == 3) load_pending();
        end

        pend_words.push_back(32'hFFFF_FFFF);
        frame(-1);
        frame(-1);
        frame(-1);
        frame(-1);

        for (int k = 1; k <= 8; k++) pend_words.push_back({16'(k), 16'(k)});
        for (int k = 0; k < 10; k++) frame(-1);

        for (int k = 0; k < 16; k++) begin
            if ($urandom_range(0, 3) != 0) pend_words.push_back($urandom);
            frame(-1);
        end

        pend_words.push_back(32'h1234_8765);
        frame(7);
        frame(-1);
        pend_words.push_back(32'hC0DE_BEEF);
        frame(-1);
        frame(-1);
        frame(-1);

        begin : drain
            int waited;
            waited = 0;
            while ((exp_q.size() > 0 || collecting) && waited < 200) begin
                step();
                waited++;
            end
            check("drain", {31'd0, (exp_q.size() > 0 || collecting)}, 32'd0);
        end
        check("rdreq_total", 32'(rd_total), 32'(exp_rd_total));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
